// File: rtl/mmio_bus_if.sv
// CPU-side request/response and shared slave-side bus of the MMIO controller.
// The master modport is the controller's view; slave is the CPU plus slaves.
interface mmio_bus_if #(
  parameter int N_SLAVES = 8
);
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_we;
  logic [31:0]              m_addr;
  logic [31:0]              m_wdata;
  logic [3:0]               m_wmask;
  logic                     m_rvalid;
  logic [31:0]              m_rdata;
  logic                     m_err;
  logic [N_SLAVES-1:0]      s_sel;
  logic                     s_we;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [3:0]               s_wmask;
  logic [N_SLAVES-1:0]      s_ack;
  logic [N_SLAVES*32-1:0]   s_rdata;

  modport master (
    input  m_valid, m_we, m_addr, m_wdata, m_wmask, s_ack, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata, s_wmask
  );

  modport slave (
    output m_valid, m_we, m_addr, m_wdata, m_wmask, s_ack, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata, s_wmask
  );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Sequential MMIO decoder: ID-table decode, valid/ack slave handshake, registered response.
// Optional MMIO_TIMEOUT_EN: bus error when a selected slave never acks.
module mmio_bus_ctrl #(
  parameter int                       N_SLAVES  = 8,
  parameter int                       ID_LSB    = 20,
  parameter int                       ID_W      = 4,
  parameter logic [N_SLAVES*ID_W-1:0] SLAVE_IDS = 32'h8765_4321,
  parameter int                       TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  mmio_bus_if.master bus
);
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [N_SLAVES-1:0] SEL_ONE = 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] hit_idx;
  logic             hit;
  logic [ID_W-1:0]  id;
  logic             sel_ack;
  logic [31:0]      slot_rdata;

`ifdef MMIO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign id = bus.m_addr[ID_LSB +: ID_W];

  // Descending scan so the lowest matching slot is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (id == SLAVE_IDS[k*ID_W +: ID_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Only the selected slot's ack counts; stray acks from other slots fall out here.
  assign sel_ack    = |(bus.s_ack & bus.s_sel);
  assign slot_rdata = bus.s_rdata[32*int'(idx_q) +: 32];
  assign bus.m_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx_q       <= '0;
      bus.s_sel   <= '0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wmask <= '0;
      bus.m_rvalid <= 1'b0;
      bus.m_rdata <= '0;
      bus.m_err   <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_valid) begin
            bus.s_we    <= bus.m_we;
            bus.s_addr  <= bus.m_addr;
            bus.s_wdata <= bus.m_wdata;
            bus.s_wmask <= bus.m_wmask;
            if (hit) begin
              idx_q     <= hit_idx;
              bus.s_sel <= SEL_ONE << hit_idx;
              state     <= ACCESS;
`ifdef MMIO_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              bus.m_rvalid <= 1'b1;
              bus.m_rdata  <= '0;
              bus.m_err    <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            bus.m_rdata  <= bus.s_we ? 32'h0 : slot_rdata;
            bus.m_err    <= 1'b0;
            bus.m_rvalid <= 1'b1;
            bus.s_sel    <= '0;
            state        <= RESP;
          end
`ifdef MMIO_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.m_rdata  <= '0;
            bus.m_err    <= 1'b1;
            bus.m_rvalid <= 1'b1;
            bus.s_sel    <= '0;
            state        <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          bus.m_rvalid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Sequential successor to the SoC's combinational address decoder.
- Sits between the CPU load/store unit and N memory-mapped slaves (dmem, seg, timer, cmem, kbd, sw, led, vga).
- Decodes a parametrised address-ID field against a per-slot ID table and runs a valid/ack handshake with the selected slave.
- Returns read data plus a bus-error flag to the CPU, with registered response timing.

Parameters:
- N_SLAVES, 8, number of slave slots, legal range 1..16.
- ID_LSB, 20, bit position of the address-ID field LSB.
- ID_W, 4, width of the address-ID field.
- SLAVE_IDS, 32'h8765_4321, packed N_SLAVES*ID_W table; slot k matches when the ID field equals bits [k*ID_W +: ID_W]. The default maps slots 0..7 to IDs 1..8.
- TIMEOUT, 16, cycles in ACCESS without ack before a bus error (used only with MMIO_TIMEOUT_EN).

Ports:
- clk  in  1  system clock. Single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_valid  in  1  CPU request valid.
- m_ready  out  1  block accepts a request this cycle.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  32  request address.
- m_wdata  in  32  write data.
- m_wmask  in  4  byte write mask.
- m_rvalid  out  1  one-cycle response strobe, for both reads and writes.
- m_rdata  out  32  read data, valid with m_rvalid.
- m_err  out  1  bus error, valid with m_rvalid.
- s_sel  out  N_SLAVES  one-hot slave select, held until ack.
- s_we  out  1  latched write enable, shared by all slaves.
- s_addr  out  32  latched address, shared.
- s_wdata  out  32  latched write data, shared.
- s_wmask  out  4  latched byte mask, shared.
- s_ack  in  N_SLAVES  per-slave completion strobe.
- s_rdata  in  N_SLAVES*32  per-slave read data; slot k is at [k*32 +: 32].

Behaviour:
- Reset (async assert, sync deassert use):
  - state = IDLE.
  - s_sel, s_we, s_addr, s_wdata, s_wmask, m_rvalid, m_rdata, m_err all = 0.
  - m_ready = 0 while rst is high.
- IDLE:
  - m_ready = 1.
  - On m_valid: latch we/addr/wdata/wmask, then decode id = m_addr[ID_LSB +: ID_W].
  - If several slots match, the lowest index wins.
  - Hit on slot k: next state ACCESS, s_sel = one-hot k from the next cycle.
  - Miss: next state RESP with m_err = 1, m_rdata = 0; no slave is selected.
- ACCESS:
  - m_ready = 0; s_sel[k] and the shared s_* outputs are held stable.
  - s_ack[k] = 1 sampled:
    - On a read, capture s_rdata slot k into m_rdata.
    - On a write, m_rdata = 0.
    - Set m_err = 0, drop s_sel, go to RESP.
  - s_ack bits of non-selected slots are ignored.
- RESP:
  - m_rvalid = 1 for exactly one cycle; m_ready = 0; next state IDLE.
  - m_rvalid, m_rdata and m_err are registered outputs.
  - m_rdata and m_err hold their values after the strobe until the next response.
- Latency:
  - Unmapped access: m_rvalid one cycle after the accept edge.
  - Slave acking in its first ACCESS cycle: m_rvalid two cycles after accept.
  - Each extra wait cycle adds one cycle.
- Back-to-back: a new request is accepted in the IDLE cycle right after RESP. Minimum throughput is one access per 3 cycles.
- m_valid while not in IDLE is ignored; the CPU holds its request until m_ready.
- Reset mid-ACCESS: s_sel drops immediately (async), the transaction is aborted, and no m_rvalid is issued.

Optional Feature:
- MMIO_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: drop s_sel, go to RESP with m_err = 1, m_rdata = 0.
  - An ack on that same cycle wins (normal response).
- MMIO_TIMEOUT_EN not defined: no counter logic; ACCESS waits for ack indefinitely.

Test Plan:
- Read hit: m_addr 0x0010_0040 (id 1, slot 0), s_ack[0] high on the first ACCESS cycle with s_rdata slot0 = 0xDEAD_BEEF -> s_sel = 8'b0000_0001 for one cycle; m_rvalid 2 cycles after accept with m_rdata 0xDEAD_BEEF, m_err 0.
- Write with wait states: addr 0x0070_0000, m_wdata 0x0000_00FF, m_wmask 4'b0001, s_ack[6] after 3 cycles -> s_sel[6] held 3 cycles; s_we 1, s_wdata 0xFF, s_wmask 4'b0001 stable throughout; m_rvalid with m_rdata 0, m_err 0.
- Unmapped access: addr 0x00F0_0000 -> s_sel stays 0; m_rvalid 1 cycle after accept with m_err 1, m_rdata 0.
- Stray ack: slot 2 selected while s_ack[3] pulses -> no response until s_ack[2].
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT = 16): addr 0x0030_0000, no ack -> s_sel[2] high 16 cycles, then m_rvalid with m_err 1. Without the macro, no response after 100 cycles.
- Async reset asserted mid-ACCESS -> s_sel 0 in the same cycle, no m_rvalid; after release, m_ready 1 and a read of 0x0010_0000 completes normally.
